// File: rtl/alu_pkg.sv
// Shared types for the logic datapath and its request arbiter.
package alu_pkg;

    // Operation encoding; order matches the result merger inside logic_block.
    typedef enum logic [1:0] {
        LOGIC_NOT_B = 2'd0,
        LOGIC_AND   = 2'd1,
        LOGIC_OR    = 2'd2,
        LOGIC_XOR   = 2'd3
    } logic_op_t;

    // Result register occupancy.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_FULL = 1'b1
    } logic_arb_state_t;

endpackage

// File: rtl/logic_block.sv
// Bitwise logic unit: NOT b, AND, OR, XOR selected by op. No carries.
module logic_block
    import alu_pkg::*;
#(
    parameter int word_width = 32
) (
    input  logic [1:0]            op_i,
    input  logic [word_width-1:0] a_i,
    input  logic [word_width-1:0] b_i,
    input  logic [word_width-1:0] not_b_i,
    output logic [word_width-1:0] r_o
);

    // Select one of the four bitwise results.
    always_comb begin
        r_o = not_b_i;
        case (logic_op_t'(op_i))
            LOGIC_NOT_B: r_o = not_b_i;
            LOGIC_AND:   r_o = a_i & b_i;
            LOGIC_OR:    r_o = a_i | b_i;
            LOGIC_XOR:   r_o = a_i ^ b_i;
            default:     r_o = not_b_i;
        endcase
    end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin sharing of one logic_block between several requesters,
// with a single registered result slot and valid/ready on both sides.
module logic_arbiter
    import alu_pkg::*;
#(
    parameter int word_width = 32,
    parameter int req_count  = 4,
    localparam int id_width  = $clog2(req_count)
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [req_count-1:0]                req_valid_i,
    output logic [req_count-1:0]                req_ready_o,
    input  logic [req_count-1:0][1:0]           req_op_i,
    input  logic [req_count-1:0][word_width-1:0] req_a_i,
    input  logic [req_count-1:0][word_width-1:0] req_b_i,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic [word_width-1:0]               resp_r_o,
    output logic [id_width-1:0]                 resp_id_o,
    output logic                                busy_o
);

    logic_arb_state_t      r_state;
    logic [id_width-1:0]   r_last_grant;
    logic [word_width-1:0] r_resp_r;
    logic [id_width-1:0]   r_resp_id;

    logic                  w_can_accept;
    logic                  w_found;
    logic [id_width-1:0]   w_pick;
    logic                  w_xfer;
    logic [1:0]            w_op;
    logic [word_width-1:0] w_a;
    logic [word_width-1:0] w_b;
    logic [word_width-1:0] w_not_b;
    logic [word_width-1:0] w_result;

    // A draining result slot can be refilled in the same cycle.
    assign w_can_accept = (r_state == ARB_IDLE) | resp_ready_i;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= req_count; i++) begin
            int idx;
            idx = (int'(r_last_grant) + i) % req_count;
            if (!w_found && req_valid_i[idx]) begin
                w_found = 1'b1;
                w_pick  = id_width'(idx);
            end
        end
    end

    // One-hot grant, suppressed while the slot is blocked or in reset.
    always_comb begin
        req_ready_o = '0;
        if (w_found && w_can_accept && rst_n_i) begin
            req_ready_o[w_pick] = 1'b1;
        end
    end

    // The grant only ever lands on a valid index, so any grant is a transfer.
    assign w_xfer  = |req_ready_o;

    assign w_op    = req_op_i[w_pick];
    assign w_a     = req_a_i[w_pick];
    assign w_b     = req_b_i[w_pick];
    assign w_not_b = ~w_b;

    logic_block #(
        .word_width (word_width)
    ) u_logic_block (
        .op_i    (w_op),
        .a_i     (w_a),
        .b_i     (w_b),
        .not_b_i (w_not_b),
        .r_o     (w_result)
    );

    // Result slot FSM: load on transfer, empty when consumed without refill.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= ARB_IDLE;
            r_resp_r     <= '0;
            r_resp_id    <= '0;
            r_last_grant <= id_width'(req_count - 1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_xfer) begin
                        r_state      <= ARB_FULL;
                        r_resp_r     <= w_result;
                        r_resp_id    <= w_pick;
                        r_last_grant <= w_pick;
                    end
                end
                ARB_FULL: begin
                    if (w_xfer) begin
                        r_resp_r     <= w_result;
                        r_resp_id    <= w_pick;
                        r_last_grant <= w_pick;
                    end else if (resp_ready_i) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign resp_valid_o = (r_state == ARB_FULL);
    assign resp_r_o     = r_resp_r;
    assign resp_id_o    = r_resp_id;
    assign busy_o       = resp_valid_o | (|req_valid_i);

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter with word_width=8, req_count=4.
module tb_logic_arbiter;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           req_valid;
    logic [3:0]           req_ready;
    logic [3:0][1:0]      req_op;
    logic [3:0][7:0]      req_a;
    logic [3:0][7:0]      req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [7:0]           resp_r;
    logic [1:0]           resp_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    logic_arbiter #(
        .word_width (8),
        .req_count  (4)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_r_o     (resp_r),
        .resp_id_o    (resp_id),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_op[k] = 2'd1;
            req_b[k]  = 8'hFF;
        end
        req_a[0] = 8'h11; req_a[1] = 8'h22; req_a[2] = 8'h33; req_a[3] = 8'h44;

        // Reset state
        tick(); tick();
        chk("rst_ready", {28'd0, req_ready}, 32'h0);
        chk("rst_valid", {31'd0, resp_valid}, 32'h0);
        chk("rst_r", {24'd0, resp_r}, 32'h0);
        chk("rst_id", {30'd0, resp_id}, 32'h0);

        // Full rotation: a passes through AND with FF, so result names the winner
        rst_n = 1'b1;
        #1;
        chk("rot_ready0", {28'd0, req_ready}, 32'h1);
        tick();
        chk("rot_valid0", {31'd0, resp_valid}, 32'h1);
        chk("rot_r0", {24'd0, resp_r}, 32'h11);
        chk("rot_id0", {30'd0, resp_id}, 32'd0);
        chk("rot_ready1", {28'd0, req_ready}, 32'h2);
        tick();
        chk("rot_r1", {24'd0, resp_r}, 32'h22);
        chk("rot_id1", {30'd0, resp_id}, 32'd1);
        chk("rot_ready2", {28'd0, req_ready}, 32'h4);
        tick();
        chk("rot_r2", {24'd0, resp_r}, 32'h33);
        chk("rot_id2", {30'd0, resp_id}, 32'd2);
        chk("rot_ready3", {28'd0, req_ready}, 32'h8);
        tick();
        chk("rot_r3", {24'd0, resp_r}, 32'h44);
        chk("rot_id3", {30'd0, resp_id}, 32'd3);
        chk("rot_ready4", {28'd0, req_ready}, 32'h1);
        tick();
        chk("rot_r4", {24'd0, resp_r}, 32'h11);
        chk("rot_id4", {30'd0, resp_id}, 32'd0);

        // Backpressure for three cycles while FULL
        resp_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready", {28'd0, req_ready}, 32'h0);
            tick();
            chk("bp_valid", {31'd0, resp_valid}, 32'h1);
            chk("bp_r", {24'd0, resp_r}, 32'h11);
            chk("bp_id", {30'd0, resp_id}, 32'd0);
        end
        chk("bp_ready_last", {28'd0, req_ready}, 32'h0);
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, req_ready}, 32'h2);
        tick();
        chk("bp_release_r", {24'd0, resp_r}, 32'h22);
        chk("bp_release_id", {30'd0, resp_id}, 32'd1);

        // Drain without refill
        req_valid = 4'h0;
        #1;
        chk("drain_busy_before", {31'd0, busy}, 32'h1);
        chk("drain_ready", {28'd0, req_ready}, 32'h0);
        tick();
        chk("drain_valid", {31'd0, resp_valid}, 32'h0);
        chk("drain_busy", {31'd0, busy}, 32'h0);

        // Single requester 1, each op, a=F0 b=3C
        req_a[1]  = 8'hF0;
        req_b[1]  = 8'h3C;
        req_op[1] = 2'd1;
        req_valid = 4'h2;
        #1;
        chk("op_ready", {28'd0, req_ready}, 32'h2);
        tick();
        chk("op_and_valid", {31'd0, resp_valid}, 32'h1);
        chk("op_and", {24'd0, resp_r}, 32'h30);
        chk("op_and_id", {30'd0, resp_id}, 32'd1);
        req_op[1] = 2'd2;
        #1;
        chk("op_ready_or", {28'd0, req_ready}, 32'h2);
        tick();
        chk("op_or", {24'd0, resp_r}, 32'hFC);
        req_op[1] = 2'd3;
        tick();
        chk("op_xor", {24'd0, resp_r}, 32'hCC);
        req_op[1] = 2'd0;
        tick();
        chk("op_notb", {24'd0, resp_r}, 32'hC3);
        chk("op_notb_id", {30'd0, resp_id}, 32'd1);
        req_valid = 4'h0;
        tick();
        chk("op_idle", {31'd0, resp_valid}, 32'h0);

        // Priority pointer: after grant to 2, 3 beats 0
        req_op[2] = 2'd1;
        req_a[2]  = 8'hFF;
        req_b[2]  = 8'h5A;
        req_valid = 4'h4;
        tick();
        chk("prio_r2", {24'd0, resp_r}, 32'h5A);
        chk("prio_id2", {30'd0, resp_id}, 32'd2);
        req_valid = 4'h9;
        #1;
        chk("prio_ready3", {28'd0, req_ready}, 32'h8);
        tick();
        chk("prio_id3", {30'd0, resp_id}, 32'd3);
        chk("prio_r3", {24'd0, resp_r}, 32'h44);
        chk("prio_ready0", {28'd0, req_ready}, 32'h1);
        tick();
        chk("prio_id0", {30'd0, resp_id}, 32'd0);
        chk("prio_r0", {24'd0, resp_r}, 32'h11);

        // Reset while FULL, with requests pending and the consumer ready
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", {28'd0, req_ready}, 32'h0);
        tick();
        chk("mrst_valid", {31'd0, resp_valid}, 32'h0);
        chk("mrst_r", {24'd0, resp_r}, 32'h0);
        chk("mrst_id", {30'd0, resp_id}, 32'd0);
        rst_n     = 1'b1;
        req_valid = 4'h5;
        #1;
        chk("mrst_ready_after", {28'd0, req_ready}, 32'h1);
        tick();
        chk("mrst_id_after", {30'd0, resp_id}, 32'd0);
        chk("mrst_r_after", {24'd0, resp_r}, 32'h11);
        chk("mrst_ready_next", {28'd0, req_ready}, 32'h4);
        tick();
        chk("mrst_id_next", {30'd0, resp_id}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
